uart_fifo_transceiver: RTL

UART_FIFO_TRANSCEIVER -- requirements
Module: uart_fifo_transceiver

---
 rtl/uart_fifo_transceiver.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_transceiver.sv
// rtl/uart_fifo_transceiver.sv - UART TX/RX with show-ahead RX FIFO; even parity when UART_PARITY_EN is defined
module uart_fifo_transceiver #(
    parameter int DATA_BITS     = 8,
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [BW-1:0]        tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 txd_n;
`ifdef UART_PARITY_EN
    logic                 tx_par, tx_par_n;
`endif

    assign tx_ready = (tx_state == TX_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // txd is registered from the next-state logic so the start bit appears the cycle after acceptance
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_valid && tx_ready) begin
                    tx_state_n = TX_START;
                    tx_shift_n = tx_data;
                    txd_n      = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_n   = ^tx_data;
`endif
                end
            end
            TX_START: if (tx_cnt == BIT_END) begin
                tx_state_n = TX_DATA;
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                txd_n      = tx_shift[0];
            end
            TX_DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_n = '0;
                if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    tx_state_n = TX_PARITY;
                    txd_n      = tx_par;
`else
                    tx_state_n = TX_STOP;
                    txd_n      = 1'b1;
`endif
                end else begin
                    tx_bit_n   = tx_bit + BW'(1);
                    tx_shift_n = tx_shift >> 1;
                    txd_n      = tx_shift[1];
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_cnt == BIT_END) begin
                tx_state_n = TX_STOP;
                tx_cnt_n   = '0;
                txd_n      = 1'b1;
            end
`endif
            TX_STOP: if (tx_cnt == BIT_END) begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = '0;
            end
            default: begin
                tx_state_n = TX_IDLE;
                txd_n      = 1'b1;
            end
        endcase
    end

    rx_state_t            rx_state, rx_state_n;
    logic [1:0]           rx_sync;
    logic                 rx_prev, rx_s;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [BW-1:0]        rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 frame_err_n, rx_push;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad, rx_par_bad_n, parity_err_n;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_s     = rx_sync[1];
    assign rx_break = (rx_state == RX_BREAK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync      <= 2'b11;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad    <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_sync      <= {rx_sync[0], rxd};
            rx_prev      <= rx_s;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_shift     <= rx_shift_n;
            rx_frame_err <= frame_err_n;
`ifdef UART_PARITY_EN
            rx_par_bad    <= rx_par_bad_n;
            rx_parity_err <= parity_err_n;
`endif
        end
    end

    // After the half-bit re-check every later sample lands mid-bit, one full period apart
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + CW'(1);
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        frame_err_n = 1'b0;
        rx_push     = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_n = rx_par_bad;
        parity_err_n = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s) rx_state_n = RX_START;
            end
            RX_START: if (rx_cnt == HALF_END) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_END) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_bit_n   = rx_bit + BW'(1);
                if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    rx_state_n = RX_PARITY;
`else
                    rx_state_n = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_cnt == BIT_END) begin
                rx_cnt_n     = '0;
                rx_par_bad_n = rx_s ^ (^rx_shift);
                rx_state_n   = RX_STOP;
            end
`endif
            RX_STOP: if (rx_cnt == BIT_END) begin
                rx_cnt_n = '0;
                if (!rx_s && rx_shift == '0) begin
                    rx_state_n = RX_BREAK;
                end else begin
                    rx_state_n = RX_IDLE;
                    if (!rx_s) frame_err_n = 1'b1;
`ifdef UART_PARITY_EN
                    else if (rx_par_bad) parity_err_n = 1'b1;
`endif
                    else rx_push = 1'b1;
                end
            end
            RX_BREAK: begin
                rx_cnt_n = '0;
                if (rx_s) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, pop, do_push;

    assign full     = (wr_ptr - rd_ptr) == (AW+1)'(RX_FIFO_DEPTH);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign pop      = rx_ready && rx_valid;
    assign do_push  = rx_push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (rx_push && full && !pop) rx_overrun <= 1'b1;
            else if (pop)                rx_overrun <= 1'b0;
        end
    end
endmodule
